// File: rtl/b9_rr_ctrl.sv
// b9_rr_ctrl - NCH-channel round-robin grant controller.
//
// Arbitrates between NCH requesters for one shared downstream resource. A
// winner is picked in IDLE by scanning from the round-robin pointer upward,
// wrapping at NCH-1. The winner then holds the grant for hold_max+1 cycles.
// Each cycle with busy_in high adds one cycle to the grant. If the granted
// request drops, the grant is cut short. Every grant ends with one RELEASE
// cycle that pulses done. All outputs come straight from flops.
//
// Optional feature (compile-time macro):
//   B9_RR_PRIORITY_EN - channel 0 wins arbitration whenever it requests,
//                       regardless of the pointer. The pointer update is
//                       unchanged.
//
// Parameters:
//   NCH     number of request channels (2..16, any value)
//   HOLD_W  width of hold counter and hold_max
//   IDW     width of gnt_id, derived as $clog2(NCH)
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req        in   [NCH]    per-channel request level, held until serviced
//   busy_in    in   downstream stall, freezes the hold counter
//   hold_max   in   [HOLD_W] grant length minus one, sampled on grant load
//   gnt        out  [NCH]    one-hot grant, zero when idle
//   gnt_valid  out  high while a grant is active (equals |gnt)
//   gnt_id     out  [IDW]    index of granted channel, holds last value
//   done       out  one-cycle pulse in the cycle after a grant ends
//   aborted    out  qualifies done: grant ended because its request dropped
module b9_rr_ctrl #(
  parameter  int NCH    = 4,
  parameter  int HOLD_W = 4,
  localparam int IDW    = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic              busy_in,
  input  logic [HOLD_W-1:0] hold_max,
  output logic [NCH-1:0]    gnt,
  output logic              gnt_valid,
  output logic [IDW-1:0]    gnt_id,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]    gnt_d;
  logic              gnt_valid_d;
  logic [IDW-1:0]    gnt_id_d;
  logic              done_d;
  logic              aborted_d;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic              end_grant;
  logic              end_abort;

  // Round-robin winner search. The candidate index is formed one bit wider
  // than IDW so that ptr+i can be wrapped by a single subtraction of NCH.
  // This works for NCH values that are not a power of 2.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [IDW:0]   cand;
      logic [IDW-1:0] cidx;
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NCH)) begin
        cand = cand - (IDW+1)'(NCH);
      end
      cidx = cand[IDW-1:0];
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
`ifdef B9_RR_PRIORITY_EN
    // Channel 0 overrides the rotation whenever it requests.
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`else
`endif
  end

  // Next-state and next-output logic. Registered outputs hold by default.
  // done/aborted default low, so each is high for exactly one cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    gnt_id_d    = gnt_id;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    end_grant   = 1'b0;
    end_abort   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = GRANT;
          gnt_d       = NCH'(1) << win_idx;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_idx;
          cnt_d       = hold_max;
        end
      end

      GRANT: begin
        // The order matters: a dropped request ends the grant even while
        // the downstream is stalled or the counter still has time left.
        if (!req[gnt_id]) begin
          end_grant = 1'b1;
          end_abort = 1'b1;
        end else if (busy_in) begin
          cnt_d = cnt_q;
        end else if (cnt_q == '0) begin
          end_grant = 1'b1;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end

        if (end_grant) begin
          state_d     = RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          done_d      = 1'b1;
          aborted_d   = end_abort;
          ptr_d       = (gnt_id == IDW'(NCH-1)) ? '0 : gnt_id + IDW'(1);
        end
      end

      // One cycle only. No arbitration happens here, so the next grant
      // always sees at least one IDLE cycle first.
      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_id    <= gnt_id_d;
      done      <= done_d;
      aborted   <= aborted_d;
    end
  end

endmodule

// File: tb/tb_b9_rr_ctrl.sv
// Testbench for b9_rr_ctrl: one NCH=4 instance and one NCH=3 instance,
// driven by the same stimulus (the NCH=3 copy sees req[2:0]). A
// transaction-level model of each instance is checked on every falling
// edge. Directed literal expectations pin the model along the way.
module tb_b9_rr_ctrl;

`ifdef B9_RR_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       busy_in;
  logic [3:0] hold_max;

  logic [3:0] gnt4;
  logic       gv4;
  logic [1:0] id4;
  logic       done4, ab4;

  logic [2:0] req3;
  logic [2:0] gnt3;
  logic       gv3;
  logic [1:0] id3;
  logic       done3, ab3;

  assign req3 = req[2:0];

  always #5 clock = ~clock;

  b9_rr_ctrl #(.NCH(4), .HOLD_W(4)) u4 (
    .clock(clock), .reset_n(reset_n), .req(req), .busy_in(busy_in),
    .hold_max(hold_max), .gnt(gnt4), .gnt_valid(gv4), .gnt_id(id4),
    .done(done4), .aborted(ab4)
  );

  b9_rr_ctrl #(.NCH(3), .HOLD_W(4)) u3 (
    .clock(clock), .reset_n(reset_n), .req(req3), .busy_in(busy_in),
    .hold_max(hold_max), .gnt(gnt3), .gnt_valid(gv3), .gnt_id(id3),
    .done(done3), .aborted(ab3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: owner = granted channel or -1. left = grant cycles still owed.
  // done = this is the cycle after a grant ended.
  typedef struct packed {
    int owner;
    int left;
    int ptr;
    int last_id;
    bit done;
    bit ab;
  } mst_t;

  function automatic mst_t mreset();
    mst_t s;
    s.owner = -1; s.left = 0; s.ptr = 0; s.last_id = 0; s.done = 1'b0; s.ab = 1'b0;
    return s;
  endfunction

  function automatic bit rb(logic [3:0] r, int k);
    return r[k[1:0]];
  endfunction

  function automatic mst_t mstep(mst_t s, int nch, logic [3:0] r, logic busy, int hm);
    mst_t n;
    bit   fin, abt;
    int   w;
    n = s; fin = 1'b0; abt = 1'b0; w = -1;
    if (s.done) begin
      n.done = 1'b0;
      n.ab   = 1'b0;
    end else if (s.owner < 0) begin
      if (PRI && r[0]) w = 0;
      else begin
        for (int i = 0; i < nch; i++)
          if (w < 0 && rb(r, (s.ptr + i) % nch)) w = (s.ptr + i) % nch;
      end
      if (w >= 0) begin
        n.owner = w; n.last_id = w; n.left = hm + 1;
      end
    end else begin
      if (!rb(r, s.owner)) begin
        fin = 1'b1; abt = 1'b1;
      end else if (!busy) begin
        if (s.left == 1) fin = 1'b1;
        else n.left = s.left - 1;
      end
      if (fin) begin
        n.done = 1'b1; n.ab = abt; n.ptr = (s.owner + 1) % nch; n.owner = -1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] mgnt(mst_t s);
    logic [3:0] g;
    g = '0;
    if (s.owner >= 0) g[s.owner[1:0]] = 1'b1;
    return g;
  endfunction

  mst_t m4, m3;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m4 <= mreset();
      m3 <= mreset();
    end else begin
      m4 <= mstep(m4, 4, req, busy_in, int'(hold_max));
      m3 <= mstep(m3, 3, {1'b0, req[2:0]}, busy_in, int'(hold_max));
    end
  end

  // Compare process on every falling edge
  always @(negedge clock) begin
    chk("u4.gnt", 32'(gnt4), 32'(mgnt(m4)));
    chk("u4.gnt_valid", 32'(gv4), 32'(m4.owner >= 0));
    chk("u4.gnt_id", 32'(id4), 32'(m4.last_id));
    chk("u4.done", 32'(done4), 32'(m4.done));
    if (m4.done) chk("u4.aborted", 32'(ab4), 32'(m4.ab));
    chk("u3.gnt", 32'(gnt3), 32'(mgnt(m3) & 4'b0111));
    chk("u3.gnt_valid", 32'(gv3), 32'(m3.owner >= 0));
    chk("u3.gnt_id", 32'(id3), 32'(m3.last_id));
    chk("u3.id_range", 32'(id3 < 2'd3), 32'd1);
    chk("u3.done", 32'(done3), 32'(m3.done));
    if (m3.done) chk("u3.aborted", 32'(ab3), 32'(m3.ab));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic nx();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b1; req = 4'b1111; busy_in = 1'b0; hold_max = 4'd2;
    #1 reset_n = 1'b0;

    // Reset holds everything low even with all channels requesting
    repeat (3) begin
      nx();
      chk("rst.gnt", 32'(gnt4), 32'd0);
      chk("rst.gnt_valid", 32'(gv4), 32'd0);
      chk("rst.done", 32'(done4), 32'd0);
      chk("rst.gnt_id", 32'(id4), 32'd0);
    end
    reset_n = 1'b1;

    // Rotation: hold_max=2, 5-cycle period
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        nx();
        chk("rot.gnt4", 32'(gnt4), 32'(1) << (k % 4));
        chk("rot.gnt3", 32'(gnt3), 32'(1) << (k % 3));
      end
      nx();
      chk("rot.done", 32'(done4), 32'd1);
      chk("rot.aborted", 32'(ab4), 32'd0);
      chk("rot.gnt_off", 32'(gnt4), 32'd0);
      nx();
      chk("rot.idle", 32'(gnt4), 32'd0);
      chk("rot.done_clr", 32'(done4), 32'd0);
    end

    // Stall: hold_max=1, ch2, busy for 3 cycles -> 5 grant cycles
    req = 4'b0100; hold_max = 4'd1;
    nx(); chk("stall.gnt", 32'(gnt4), 32'h4);
    busy_in = 1'b1;
    repeat (3) begin nx(); chk("stall.gnt", 32'(gnt4), 32'h4); end
    busy_in = 1'b0;
    nx(); chk("stall.gnt", 32'(gnt4), 32'h4); chk("stall.gnt3", 32'(gnt3), 32'h4);
    nx(); chk("stall.done", 32'(done4), 32'd1); chk("stall.ab", 32'(ab4), 32'd0);
    chk("stall.gnt_off", 32'(gnt4), 32'd0);
    req = 4'b0010; hold_max = 4'd15;
    nx(); chk("stall.idle", 32'(gnt4), 32'd0);

    // Abort: ch1, drop request on the 4th grant cycle
    repeat (4) begin nx(); chk("abort.gnt", 32'(gnt4), 32'h2); end
    req = 4'b0000;
    nx(); chk("abort.gnt_off", 32'(gnt4), 32'd0);
    chk("abort.done", 32'(done4), 32'd1); chk("abort.ab", 32'(ab4), 32'd1);
    chk("abort.ab3", 32'(ab3), 32'd1);
    req = 4'b1111; hold_max = 4'd0;
    nx(); chk("abort.idle", 32'(gnt4), 32'd0);
    nx(); chk("abort.ptr_gnt", 32'(gnt4), 32'h4); chk("abort.ptr_id", 32'(id4), 32'd2);
    chk("abort.ptr_gnt3", 32'(gnt3), 32'h4);
    nx(); chk("hm0.done", 32'(done4), 32'd1); chk("hm0.ab", 32'(ab4), 32'd0);

    // Wrap: ch0 first to park both pointers at 1, then req {2,0} -> 2 then 0
    req = 4'b0001;
    nx(); nx(); chk("wrap.pre", 32'(gnt3), 32'h1);
    nx(); req = 4'b0101;
    nx(); nx(); chk("wrap.g2_3", 32'(gnt3), 32'h4); chk("wrap.id2_3", 32'(id3), 32'd2);
    chk("wrap.g2_4", 32'(gnt4), 32'h4);
    nx(); req = 4'b0001;
    nx(); nx(); chk("wrap.g0_3", 32'(gnt3), 32'h1); chk("wrap.id0_3", 32'(id3), 32'd0);
    chk("wrap.g0_4", 32'(gnt4), 32'h1);

    // Priority: ch1 grant moves pointer to 2, then req=1101
    nx(); req = 4'b0010;
    nx(); nx(); chk("pri.pre", 32'(gnt4), 32'h2);
    nx(); req = 4'b1101;
    nx(); nx();
    chk("pri.gnt4", 32'(gnt4), PRI ? 32'h1 : 32'h4);
    chk("pri.gnt3", 32'(gnt3), PRI ? 32'h1 : 32'h4);

    // Reset in the middle of a grant
    nx(); req = 4'b1111; hold_max = 4'd5;
    nx(); nx(); chk("mrst.pre", 32'(gv4), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst.gnt", 32'(gnt4), 32'd0); chk("mrst.gv", 32'(gv4), 32'd0);
    chk("mrst.id", 32'(id4), 32'd0); chk("mrst.gnt3", 32'(gnt3), 32'd0);
    nx(); chk("mrst.nodone", 32'(done4), 32'd0);
    reset_n = 1'b1;
    nx(); chk("mrst.regrant", 32'(gnt4), 32'h1);
    repeat (12) nx();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
